buzzer_sequencer: RTL

Bus-programmable note sequencer for the buzzer output. The CPU writes note entries into a small FIFO through the same `CS_N`/`IOW_N` style port the I/O modules use. Each entry holds a half-period and a duration. The sequencer plays the entries in order as a square wave on `buzzer`, so the CPU no longer has to gate the output itself.

---
 rtl/buzzer_pkg.sv | 30 +++
 rtl/buzzer_note_fifo.sv | 53 +++++
 rtl/buzzer_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/buzzer_pkg.sv
// Shared types and register map for the buzzer note sequencer.
package buzzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP
    } state_t;

    localparam logic [1:0] ADDR_PER_LO = 2'd0;
    localparam logic [1:0] ADDR_PER_HI = 2'd1;
    localparam logic [1:0] ADDR_PUSH   = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;

    typedef struct packed {
        logic [15:0] per;
        logic [7:0]  dur;
    } note_t;

endpackage

// File: rtl/buzzer_note_fifo.sv
// Synchronous FIFO of note entries; pushes when full and pops when empty are ignored.
module buzzer_note_fifo
    import buzzer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  note_t                      wdata,
    output note_t                      rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    note_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/buzzer_sequencer.sv
// Bus-programmable note sequencer driving a square wave on buzzer.
// Define BUZZER_GAP_EN to follow every sounding note with one duration unit of silence.
module buzzer_sequencer
    import buzzer_pkg::*;
#(
    parameter int TONE_DIV  = 100,
    parameter int DUR_TICKS = 10000,
    parameter int DEPTH     = 8
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       CS_N,
    input  logic       IOW_N,
    input  logic       IOR_N,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       buzzer,
    output logic       busy
);
    localparam int PW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int DW = $clog2(255 * DUR_TICKS + 1);
    localparam int CW = $clog2(DEPTH + 1);

    logic          wr_now, wr_prev, wr_ev;
    logic          rd_now, rd_prev, rd_ev;
    logic          push, ctrl_wr, flush, abort, pop;
    logic [7:0]    per_lo, per_hi;
    logic          enable, ovf;
    note_t         head;
    logic          full, empty;
    logic [CW-1:0] count;
    logic [3:0]    cnt_sat;
    logic [7:0]    status;

    state_t        state;
    logic [15:0]   note_per;
    logic [DW-1:0] target, tcnt, tcnt_nxt;
    logic [15:0]   hcnt, hcnt_nxt;
    logic [PW-1:0] presc;
    logic          tick;

    assign wr_now  = !CS_N && !IOW_N;
    assign rd_now  = !CS_N && !IOR_N;
    assign wr_ev   = wr_now && !wr_prev;
    assign rd_ev   = rd_now && !rd_prev;
    assign push    = wr_ev && (addr == ADDR_PUSH);
    assign ctrl_wr = wr_ev && (addr == ADDR_CTRL);
    assign flush   = ctrl_wr && din[CTRL_FLUSH];
    assign abort   = ctrl_wr && (!din[CTRL_ENABLE] || din[CTRL_FLUSH]);
    assign pop     = (state == ST_LOAD);

    buzzer_note_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_in (clk_in),
        .rst    (rst),
        .flush  (flush),
        .push   (push),
        .pop    (pop),
        .wdata  ({per_hi, per_lo, din}),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_comb begin
        cnt_sat = (32'(count) > 15) ? 4'hF : 4'(count);
        status = '0;
        status[STAT_BUSY]            = busy;
        status[STAT_FULL]            = full;
        status[STAT_EMPTY]           = empty;
        status[STAT_OVF]             = ovf;
        status[STAT_CNT_LSB +: 4]    = cnt_sat;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_prev <= 1'b0;
            rd_prev <= 1'b0;
            per_lo  <= '0;
            per_hi  <= '0;
            enable  <= 1'b0;
            ovf     <= 1'b0;
            dout    <= '0;
        end else begin
            wr_prev <= wr_now;
            rd_prev <= rd_now;
            if (wr_ev && addr == ADDR_PER_LO) per_lo <= din;
            if (wr_ev && addr == ADDR_PER_HI) per_hi <= din;
            if (ctrl_wr) enable <= din[CTRL_ENABLE];
            // A full FIFO drops the push even if the sequencer pops this same cycle.
            if (flush)              ovf <= 1'b0;
            else if (push && full)  ovf <= 1'b1;
            if (rd_ev)        dout <= (addr == ADDR_CTRL) ? status : 8'h00;
            else if (!rd_now) dout <= 8'h00;
        end
    end

    assign tick     = (presc == PW'(TONE_DIV - 1));
    assign tcnt_nxt = tcnt + DW'(1);
    assign hcnt_nxt = hcnt + 16'd1;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state  <= ST_IDLE;
            buzzer <= 1'b0;
            busy   <= 1'b0;
        end else if (abort) begin
            state  <= ST_IDLE;
            buzzer <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && !empty) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    note_per <= head.per;
                    target   <= DW'(head.dur) * DW'(DUR_TICKS);
                    presc    <= '0;
                    tcnt     <= '0;
                    hcnt     <= '0;
                    if (head.dur == 8'd0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state  <= ST_PLAY;
                        buzzer <= (head.per != 16'd0);
                    end
                end
                ST_PLAY: begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (tick) begin
                        if (tcnt_nxt == target) begin
                            tcnt   <= '0;
                            buzzer <= 1'b0;
`ifdef BUZZER_GAP_EN
                            state  <= ST_GAP;
`else
                            state  <= ST_IDLE;
                            busy   <= 1'b0;
`endif
                        end else begin
                            tcnt <= tcnt_nxt;
                            if (note_per != 16'd0) begin
                                if (hcnt_nxt == note_per) begin
                                    hcnt   <= '0;
                                    buzzer <= !buzzer;
                                end else begin
                                    hcnt <= hcnt_nxt;
                                end
                            end
                        end
                    end
                end
`ifdef BUZZER_GAP_EN
                ST_GAP: begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (tick) begin
                        if (tcnt_nxt == DW'(DUR_TICKS)) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            tcnt <= tcnt_nxt;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
